// File: rtl/cache_mem_arbiter_if.sv
// Bundle of the icache, dcache and RAM signals that meet at the memory arbiter.
// The "slave" view belongs to the arbiter; the "master" view is the cache/RAM side.
interface cache_mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares one RAM port between the icache and dcache. The dcache has priority,
// but after MAX_D_STREAK back-to-back D grants with the icache waiting, the
// icache gets the next grant. Every RAM access is bounded by TIMEOUT_CYC; an
// ERROR status or a timeout releases the waiting cache with zero data and sets
// a sticky err flag.
module cache_mem_arbiter #(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT_CYC  = 64
) (
  input  logic                CLK,
  input  logic                RST,
  cache_mem_arbiter_if.slave  bus,
  output logic                err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
  localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT_CYC - 1);

  state_t        state;
  logic [SW-1:0] streak;
  logic [TW-1:0] tcnt;

  logic dreq;
  logic granted_req;
  logic done;
  logic fault;
  logic release_now;

  // Saturating increment of the D-grant streak counter.
  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    sat_inc = (v == STREAK_MAX) ? v : v + SW'(1);
  endfunction

  // Decode the request/RAM status into completion and fault conditions.
  always_comb begin
    dreq        = bus.dREN | bus.dWEN;
    granted_req = 1'b0;
    if (state == SERVE_D) begin
      granted_req = dreq;
    end else if (state == SERVE_I) begin
      granted_req = bus.iREN;
    end else begin
      granted_req = 1'b0;
    end
    done        = granted_req & (bus.ramstate == RAM_ACCESS);
    fault       = granted_req & (bus.ramstate != RAM_ACCESS) &
                  ((bus.ramstate == RAM_ERROR) | (tcnt == TCNT_LAST));
    release_now = done | fault;
  end

  // Drive cache and RAM outputs from the current grant; requesters not being
  // served always see a stall while their request is up.
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = 32'h0;
    bus.ramstore = 32'h0;
    bus.iload    = 32'h0;
    bus.dload    = 32'h0;
    bus.iwait    = bus.iREN;
    bus.dwait    = dreq;
    case (state)
      SERVE_D: begin
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.dload    = fault ? 32'h0 : bus.ramload;
        bus.dwait    = ~release_now;
      end
      SERVE_I: begin
        bus.ramREN   = bus.iREN;
        bus.ramaddr  = bus.iaddr;
        bus.iload    = fault ? 32'h0 : bus.ramload;
        bus.iwait    = ~release_now;
      end
      default: begin
        bus.ramREN = 1'b0;
      end
    endcase
  end

  // Grant FSM with streak, access timer and sticky error flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      streak <= '0;
      tcnt   <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (dreq && !(bus.iREN && (streak == STREAK_MAX))) begin
            state <= SERVE_D;
          end else if (bus.iREN) begin
            state <= SERVE_I;
          end else begin
            state <= IDLE;
          end
        end
        SERVE_D: begin
          if (!dreq) begin
            state <= IDLE;
          end else if (release_now) begin
            state  <= IDLE;
            streak <= bus.iREN ? sat_inc(streak) : '0;
            if (fault) err <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        SERVE_I: begin
          if (!bus.iREN) begin
            state <= IDLE;
          end else if (release_now) begin
            state  <= IDLE;
            streak <= '0;
            if (fault) err <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter. A small RAM model answers with a
// programmable latency, stuck-BUSY or ERROR. Expected completions are queued as
// requests are issued and checked by a monitor when a cache is released.
module tb_cache_mem_arbiter;

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic [31:0] load;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  // RAM model controls: 0 normal latency, 1 stuck BUSY, 2 ERROR
  int          ram_mode = 0;
  int          ram_lat  = 1;
  int          ram_cnt  = 0;
  logic [31:0] ram_data = 32'h0;

  cache_mem_arbiter_if bus();

  cache_mem_arbiter #(.MAX_D_STREAK(4), .TIMEOUT_CYC(64)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus),
    .err (err)
  );

  always #5 clk = ~clk;

  // RAM status/data seen by the arbiter.
  always_comb begin
    bus.ramstate = 2'd0;
    if (bus.ramREN || bus.ramWEN) begin
      if (ram_mode == 2) bus.ramstate = 2'd3;
      else if (ram_mode == 0 && ram_cnt == ram_lat - 1) bus.ramstate = 2'd2;
      else bus.ramstate = 2'd1;
    end
    bus.ramload = (bus.ramstate == 2'd2) ? ram_data : 32'h5A5A5A5A;
  end

  // RAM latency counter: counts enabled cycles of the current access.
  always @(posedge clk) begin
    if ((bus.ramREN || bus.ramWEN) && bus.ramstate != 2'd2) ram_cnt <= ram_cnt + 1;
    else ram_cnt <= 0;
  end

  // Monitor: port exclusivity every cycle, scoreboard on every release.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      vectors++;
      if (bus.ramREN && bus.ramWEN) begin
        miscompares++;
        $display("FAIL ram_overlap: ramREN=%b ramWEN=%b, required not both 1", bus.ramREN, bus.ramWEN);
      end
      if ((bus.iREN && !bus.iwait) || ((bus.dREN || bus.dWEN) && !bus.dwait)) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL sb_unexpected: release at %0t with empty scoreboard", $time);
        end else begin
          exp_t e;
          logic is_d;
          logic [31:0] ld;
          e    = sb.pop_front();
          is_d = (bus.dREN || bus.dWEN) && !bus.dwait;
          ld   = is_d ? bus.dload : bus.iload;
          if (is_d !== e.is_d || bus.ramaddr !== e.addr || ld !== e.load) begin
            miscompares++;
            $display("FAIL sb_release: got d=%b addr=%h load=%h, required d=%b addr=%h load=%h",
                     is_d, bus.ramaddr, ld, e.is_d, e.addr, e.load);
          end
        end
      end
    end
  end

  // Hard bound on total run time.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    @(negedge clk);
    #1;
    vectors++;
    if (err !== 1'b0 || bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0 || bus.ramaddr !== 32'h0 ||
        bus.ramstore !== 32'h0 || bus.iload !== 32'h0 || bus.dload !== 32'h0 ||
        bus.iwait !== 1'b0 || bus.dwait !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: err=%b rr=%b rw=%b ra=%h rs=%h il=%h dl=%h iw=%b dw=%b, required all 0",
               err, bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.iload, bus.dload, bus.iwait, bus.dwait);
    end
    bus.iREN = 1'b1;
    bus.dWEN = 1'b1;
    #1;
    vectors++;
    if (bus.iwait !== 1'b1 || bus.dwait !== 1'b1 || bus.ramWEN !== 1'b0 || bus.ramREN !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_stall: iwait=%b dwait=%b rr=%b rw=%b, required 1 1 0 0",
               bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN);
    end
    bus.iREN = 1'b0;
    bus.dWEN = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    ram_mode = 0;
    ram_lat  = 3;
    ram_data = 32'hDEADBEEF;
    sb.push_back('{1'b0, 32'h40, 32'hDEADBEEF});
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      bus.iREN  = (c <= 3);
      bus.iaddr = 32'h40;
      #1;
      vectors++;
      if (bus.ramREN !== (c >= 1 && c <= 3) || bus.ramWEN !== 1'b0 ||
          bus.iwait !== (c <= 3 && c != 3 ? 1'b1 : 1'b0)) begin
        miscompares++;
        $display("FAIL single_read c%0d: ramREN=%b ramWEN=%b iwait=%b", c, bus.ramREN, bus.ramWEN, bus.iwait);
      end
      if (c == 3) begin
        vectors++;
        if (bus.iload !== 32'hDEADBEEF || bus.ramaddr !== 32'h40) begin
          miscompares++;
          $display("FAIL single_read_data: iload=%h ramaddr=%h, required deadbeef 00000040", bus.iload, bus.ramaddr);
        end
      end
    end
  endtask

  task automatic test_priority();
    logic [5:0] rr_tab = 6'b110000;
    logic [5:0] rw_tab = 6'b000110;
    logic [5:0] iw_tab = 6'b011111;
    logic [5:0] dw_tab = 6'b000011;
    ram_mode = 0;
    ram_lat  = 2;
    ram_data = 32'hCAFEF00D;
    bus.daddr  = 32'h80;
    bus.dstore = 32'h1234;
    bus.iaddr  = 32'h44;
    sb.push_back('{1'b1, 32'h80, 32'hCAFEF00D});
    sb.push_back('{1'b0, 32'h44, 32'hCAFEF00D});
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      bus.dWEN = (c < 3);
      bus.iREN = 1'b1;
      #1;
      vectors++;
      if (bus.ramREN !== rr_tab[c] || bus.ramWEN !== rw_tab[c] ||
          bus.iwait !== iw_tab[c] || bus.dwait !== dw_tab[c]) begin
        miscompares++;
        $display("FAIL priority c%0d: rr=%b rw=%b iw=%b dw=%b, required %b %b %b %b", c,
                 bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, rr_tab[c], rw_tab[c], iw_tab[c], dw_tab[c]);
      end
      if (c == 1) begin
        vectors++;
        if (bus.ramstore !== 32'h1234 || bus.ramaddr !== 32'h80) begin
          miscompares++;
          $display("FAIL priority_write: ramstore=%h ramaddr=%h, required 00001234 00000080", bus.ramstore, bus.ramaddr);
        end
      end
    end
    @(negedge clk);
    bus.iREN = 1'b0;
  endtask

  task automatic test_starvation();
    string seq = "";
    int    done_cnt = 0;
    logic  i_pend = 1'b1;
    ram_mode = 0;
    ram_lat  = 1;
    ram_data = 32'h00C0FFEE;
    bus.daddr = 32'h100;
    bus.iaddr = 32'h200;
    for (int k = 0; k < 4; k++) sb.push_back('{1'b1, 32'h100, 32'h00C0FFEE});
    sb.push_back('{1'b0, 32'h200, 32'h00C0FFEE});
    sb.push_back('{1'b1, 32'h100, 32'h00C0FFEE});
    for (int c = 0; c < 40 && done_cnt < 6; c++) begin
      @(negedge clk);
      bus.dREN = 1'b1;
      bus.iREN = i_pend;
      #1;
      if (bus.dREN && !bus.dwait) begin
        seq = {seq, "D"};
        done_cnt++;
      end else if (bus.iREN && !bus.iwait) begin
        seq = {seq, "I"};
        done_cnt++;
        i_pend = 1'b0;
      end
    end
    @(negedge clk);
    bus.dREN = 1'b0;
    bus.iREN = 1'b0;
    vectors++;
    if (seq != "DDDDID") begin
      miscompares++;
      $display("FAIL starvation_order: got %s, required DDDDID", seq);
    end
  endtask

  task automatic test_abort();
    ram_mode  = 1;
    bus.daddr = 32'h400;
    bus.iaddr = 32'h60;
    ram_data  = 32'h600D0060;
    sb.push_back('{1'b0, 32'h60, 32'h600D0060});
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      bus.dREN = (c <= 2);
      bus.iREN = (c >= 4 && c <= 5);
      if (c == 3) begin
        ram_mode = 0;
        ram_lat  = 1;
      end
      #1;
      vectors++;
      if (bus.ramREN !== (c == 1 || c == 2 || c == 5) || err !== 1'b0) begin
        miscompares++;
        $display("FAIL abort c%0d: ramREN=%b err=%b", c, bus.ramREN, err);
      end
      if (c == 5) begin
        vectors++;
        if (bus.ramaddr !== 32'h60 || bus.iwait !== 1'b0) begin
          miscompares++;
          $display("FAIL abort_regrant: ramaddr=%h iwait=%b, required 00000060 0", bus.ramaddr, bus.iwait);
        end
      end
    end
  endtask

  task automatic test_ram_error();
    ram_mode  = 2;
    bus.iaddr = 32'h70;
    sb.push_back('{1'b0, 32'h70, 32'h0});
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      bus.iREN = (c <= 1);
      #1;
      vectors++;
      if (bus.iwait !== (c == 0) || err !== (c == 2)) begin
        miscompares++;
        $display("FAIL ram_error c%0d: iwait=%b err=%b", c, bus.iwait, err);
      end
    end
    ram_mode = 0;
  endtask

  task automatic test_async_reset();
    ram_mode  = 1;
    bus.iaddr = 32'h90;
    for (int c = 0; c <= 1; c++) begin
      @(negedge clk);
      bus.iREN = 1'b1;
    end
    #1;
    vectors++;
    if (bus.ramREN !== 1'b1 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL async_pre: ramREN=%b err=%b, required 1 1", bus.ramREN, err);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.ramREN !== 1'b0 || err !== 1'b0 || bus.iwait !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset: ramREN=%b err=%b iwait=%b, required 0 0 1", bus.ramREN, err, bus.iwait);
    end
    @(negedge clk);
    bus.iREN = 1'b0;
    rst = 1'b0;
    ram_mode = 0;
  endtask

  task automatic test_timeout();
    ram_mode  = 1;
    bus.daddr = 32'h300;
    sb.push_back('{1'b1, 32'h300, 32'h0});
    for (int c = 0; c <= 65; c++) begin
      @(negedge clk);
      bus.dREN = (c <= 64);
      #1;
      vectors++;
      if (bus.dwait !== (c <= 63) || err !== (c == 65) || bus.ramREN !== (c >= 1 && c <= 64)) begin
        miscompares++;
        $display("FAIL timeout c%0d: dwait=%b err=%b ramREN=%b", c, bus.dwait, err, bus.ramREN);
      end
      if (c == 64) begin
        vectors++;
        if (bus.dload !== 32'h0) begin
          miscompares++;
          $display("FAIL timeout_load: dload=%h, required 00000000", bus.dload);
        end
      end
    end
    ram_mode  = 0;
    ram_lat   = 2;
    ram_data  = 32'h11112222;
    bus.iaddr = 32'h50;
    sb.push_back('{1'b0, 32'h50, 32'h11112222});
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      bus.iREN = (c <= 2);
      #1;
      vectors++;
      if (bus.iwait !== (c <= 1) || err !== 1'b1) begin
        miscompares++;
        $display("FAIL post_timeout c%0d: iwait=%b err=%b, required %b 1", c, bus.iwait, err, (c <= 1));
      end
    end
  endtask

  initial begin
    bus.iREN   = 1'b0;
    bus.iaddr  = 32'h0;
    bus.dREN   = 1'b0;
    bus.dWEN   = 1'b0;
    bus.daddr  = 32'h0;
    bus.dstore = 32'h0;
    test_reset();
    test_single_read();
    test_priority();
    test_starvation();
    test_abort();
    test_ram_error();
    test_async_reset();
    test_timeout();
    repeat (2) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: %0d expected releases never seen, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
